// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl : RV32M sequencer for the multicycle core.
//
// Multiply ops (MUL/MULH/MULHSU/MULHU) are handed to the shared ALU for a
// single MUL_ISSUE cycle and the ALU result is registered into result_o.
// Divide/remainder ops (DIV/DIVU/REM/REMU) run an internal restoring divider
// (one shift-subtract step per cycle) followed by a sign-fix cycle.
//
// Optional feature (compile-time macro MULDIV_EARLY_OUT_EN):
//   when defined, a normal-path divide with |dividend| < |divisor| skips the
//   iteration phase (quotient 0, remainder = dividend).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           request pulse, accepted in IDLE or DONE
//   flush_i           synchronous abort of the in-flight op (wins over start)
//   funct3_i          RV32M funct3, sampled with start_i
//   rs1_i, rs2_i      operands, sampled with start_i
//   alu_op_o/a_o/b_o  request to shared ALU (ADD/0/0 outside MUL_ISSUE)
//   alu_result_i      combinational ALU result
//   busy_o            op in flight (MUL_ISSUE, DIV_RUN, DIV_FIX)
//   done_o            one-cycle completion pulse (DONE)
//   result_o          final result, held until overwritten by a later op
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_ISSUE,
    S_DIV_RUN,
    S_DIV_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;       // funct3[1:0]; funct3[2] is implied by path
  logic [XLEN-1:0] quot_q, quot_d;   // dividend/quotient shift reg; mul operand A
  logic [XLEN-1:0] rem_q, rem_d;     // partial remainder
  logic [XLEN-1:0] dvsr_q, dvsr_d;   // divisor magnitude; mul operand B
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d;   // negate quotient at fix-up
  logic            negr_q, negr_d;   // negate remainder at fix-up
  logic [XLEN-1:0] result_q, result_d;

  // ---- accept-time decode ----
  logic            busy_st, accept, is_sgn, a_neg, b_neg, div_zero, ovf, early;
  logic [XLEN-1:0] a_mag, b_mag;

  assign busy_st  = (state_q == S_MUL_ISSUE) || (state_q == S_DIV_RUN) ||
                    (state_q == S_DIV_FIX);
  assign accept   = start_i && !flush_i &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));
  // DIV (100) and REM (110) are the signed divide ops.
  assign is_sgn   = funct3_i[2] && !funct3_i[0];
  assign a_neg    = is_sgn && rs1_i[XLEN-1];
  assign b_neg    = is_sgn && rs2_i[XLEN-1];
  assign a_mag    = a_neg ? (~rs1_i + 1'b1) : rs1_i;
  assign b_mag    = b_neg ? (~rs2_i + 1'b1) : rs2_i;
  assign div_zero = (rs2_i == '0);
  assign ovf      = is_sgn && (rs1_i == SMIN) && (rs2_i == '1);
`ifdef MULDIV_EARLY_OUT_EN
  assign early    = (a_mag < b_mag);
`else
  assign early    = 1'b0;
`endif

  // ---- one restoring step ----
  // shifted < 2*divisor, so bit XLEN of the difference is a clean borrow flag.
  logic [XLEN:0]   shifted, trial;
  logic            qbit;
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign qbit    = !trial[XLEN];

  // ---- sign fix ----
  logic [XLEN-1:0] q_fix, r_fix;
  assign q_fix = negq_q ? (~quot_q + 1'b1) : quot_q;
  assign r_fix = negr_q ? (~rem_q + 1'b1) : rem_q;

  // ---- next state ----
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    if (flush_i && busy_st) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_d   = funct3_i[1:0];
            negq_d = 1'b0;
            negr_d = 1'b0;
            cnt_d  = '0;
            if (!funct3_i[2]) begin
              // Multiply: operands parked in the divider registers.
              quot_d  = rs1_i;
              dvsr_d  = rs2_i;
              state_d = S_MUL_ISSUE;
            end else if (div_zero) begin
              quot_d  = '1;
              rem_d   = rs1_i;
              state_d = S_DIV_FIX;
            end else if (ovf) begin
              quot_d  = SMIN;
              rem_d   = '0;
              state_d = S_DIV_FIX;
            end else if (early) begin
              quot_d  = '0;
              rem_d   = rs1_i;
              state_d = S_DIV_FIX;
            end else begin
              quot_d  = a_mag;
              rem_d   = '0;
              dvsr_d  = b_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              state_d = S_DIV_RUN;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL_ISSUE: begin
          result_d = alu_result_i;
          state_d  = S_DONE;
        end
        S_DIV_RUN: begin
          rem_d  = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], qbit};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(DIV_CYCLES - 1)) state_d = S_DIV_FIX;
        end
        S_DIV_FIX: begin
          result_d = op_q[1] ? r_fix : q_fix;
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // ---- outputs ----
  always_comb begin
    alu_op_o = 4'b0000;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (state_q == S_MUL_ISSUE) begin
      unique case (op_q)
        2'b00: alu_op_o = 4'b1010;
        2'b01: alu_op_o = 4'b1011;
        2'b10: alu_op_o = 4'b1100;
        default: alu_op_o = 4'b1101;
      endcase
      alu_a_o = quot_q;
      alu_b_o = dvsr_q;
    end
  end

  assign busy_o   = busy_st;
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the RV32M instructions in the multicycle core.
- Multiply ops (MUL/MULH/MULHSU/MULHU) are issued to the shared ALU with a one-cycle registered capture.
- Divide/remainder ops (DIV/DIVU/REM/REMU) run an internal 32-iteration restoring divider, plus a sign-fix step.
- The main control FSM sees a start/busy/done handshake with a registered result.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_CYCLES, 32, number of restoring iterations; must equal XLEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  request pulse; accepted only in IDLE or DONE.
- flush_i  input  1  synchronous abort of the in-flight op.
- funct3_i  input  3  RV32M funct3, sampled with start_i.
- rs1_i  input  XLEN  operand A / dividend, sampled with start_i.
- rs2_i  input  XLEN  operand B / divisor, sampled with start_i.
- alu_op_o  output  4  ALUOp driven to the shared ALU.
- alu_a_o  output  XLEN  ALU operand A.
- alu_b_o  output  XLEN  ALU operand B.
- alu_result_i  input  XLEN  ALU result, combinational from alu_op_o/a/b.
- busy_o  output  1  high while an op is in flight.
- done_o  output  1  one-cycle completion pulse.
- result_o  output  XLEN  final result; held until the next accepted start.

Behaviour:
- Reset: clock and reset ports are clk and rst_n; one clock; reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE, all registers cleared.
  - busy_o=0, done_o=0, result_o=0, alu_op_o=4'b0000 (ADD), alu_a_o=0, alu_b_o=0.
- States: IDLE, MUL_ISSUE, DIV_RUN, DIV_FIX, DONE.
- Accept: start_i=1 in IDLE or DONE latches funct3_i, rs1_i and rs2_i. start_i in any other state is ignored.
- funct3 map:
  - 000 MUL -> ALUOp 1010
  - 001 MULH -> 1011
  - 010 MULHSU -> 1100
  - 011 MULHU -> 1101
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Multiply path:
  - Accept -> MUL_ISSUE. For that one cycle, alu_op_o/alu_a_o/alu_b_o carry the latched op and operands.
  - alu_result_i is captured into result_o at the end of MUL_ISSUE -> DONE.
  - Latency: start in cycle 0, done_o in cycle 2.
  - Outside MUL_ISSUE, the ALU outputs return to ADD/0/0.
- Divide fast paths (decided at accept; go via DIV_FIX straight to DONE, done_o in cycle 2):
  - Divisor 0: quotient = 32'hFFFF_FFFF, remainder = dividend.
  - Signed overflow (DIV/REM with rs1=32'h8000_0000, rs2=32'hFFFF_FFFF): quotient = 32'h8000_0000, remainder = 0.
- Divide normal path:
  - Operands are converted to magnitudes for signed ops (DIV/REM).
  - DIV_RUN executes one restoring shift-subtract step per cycle; a 5-bit counter runs 0..31.
  - After the count-31 cycle -> DIV_FIX, which negates the quotient if operand signs differ (signed only) and gives the remainder the dividend's sign (signed only).
  - DIV_FIX selects quotient (DIV/DIVU) or remainder (REM/REMU) into result_o -> DONE.
  - Latency: start in cycle 0, DIV_RUN cycles 1-32, DIV_FIX cycle 33, done_o in cycle 34.
- busy_o=1 in MUL_ISSUE, DIV_RUN and DIV_FIX. done_o=1 only in DONE.
- DONE lasts one cycle, then goes to IDLE unless start_i=1, which accepts a new op back-to-back.
- flush_i=1 in any busy state -> IDLE next cycle. No done_o; result_o keeps its previous value. flush_i has priority over start_i.
- Reset asserted mid-operation aborts immediately (asynchronously) to reset values.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: on the divide normal path, if |dividend| < |divisor| at accept, skip DIV_RUN. The quotient is 0 and the remainder is the original dividend; DIV_FIX then DONE, so done_o is in cycle 2.
- Undefined: every non-special divide takes the full 34-cycle latency.

Test Plan:
- MULH rs1=32'hFFFF_FFFE (-2), rs2=32'h0000_0003 -> ALU sees op 1011 in cycle 1; done_o in cycle 2; result_o=32'hFFFF_FFFF.
- DIV rs1=-20 (32'hFFFF_FFEC), rs2=3 -> done_o in cycle 34; result_o=32'hFFFF_FFFA (-6). REM with the same operands -> 32'hFFFF_FFFE (-2).
- DIVU rs1=100, rs2=0 -> done_o in cycle 2, result 32'hFFFF_FFFF. REMU with the same operands -> 100. DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000 in cycle 2.
- DIVU 7/9 -> result 0; done_o in cycle 2 with MULDIV_EARLY_OUT_EN defined, cycle 34 without it.
- Start DIVU 1000/7, flush_i in cycle 10 -> busy_o=0 in cycle 11, no done_o, result_o unchanged. Start_i during DIV_RUN is ignored.
- rst_n pulled low in cycle 15 of a DIV -> outputs zero immediately. After release, MUL 6*7 completes with result 42 in cycle 2. A back-to-back start in DONE is accepted with no idle cycle.
